// File: rtl/mem_access_ctrl.sv
// Arbitrates a single-port synchronous-read data RAM between the core load/store
// path and a debug/loader port, with internal read-modify-write for sub-word stores.
module mem_access_ctrl #(
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [31:0]   core_addr,
   input  logic [31:0]   core_wdata,
   input  logic [3:0]    core_wstrb,
   output logic [31:0]   core_rdata,
   output logic          core_ready,
   output logic          core_hold,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [31:0]   dbg_addr,
   input  logic [31:0]   dbg_wdata,
   output logic [31:0]   dbg_rdata,
   output logic          dbg_ready,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD      = 3'd2,
      RD_WAIT = 3'd3,
      RMW_RD  = 3'd4,
      RMW_WR  = 3'd5
   } state_t;

   state_t          state;
   state_t          grant_next;
   logic            last_d;
   logic            gnt_d;
   logic [AW-1:0]   addr_q;
   logic [31:0]     wdata_q;
   logic [3:0]      wstrb_q;

   logic            pick_c;
   logic            pick_d;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [31:0]     sel_wdata;
   logic [3:0]      sel_strb;
   logic            done;

   // Byte-offset and aliased upper address bits carry no information for the RAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{core_addr[31:AW+2], core_addr[1:0],
                               dbg_addr[31:AW+2], dbg_addr[1:0]};

   // Round-robin arbitration: on a tie the requester that was not granted last wins.
   always_comb begin
      pick_c    = core_req && (!dbg_req || last_d);
      pick_d    = dbg_req && !pick_c;
      sel_we    = pick_d ? dbg_we : core_we;
      sel_addr  = pick_d ? dbg_addr[AW+1:2] : core_addr[AW+1:2];
      sel_wdata = pick_d ? dbg_wdata : core_wdata;
      sel_strb  = pick_d ? 4'hF : core_wstrb;
      if (!sel_we) begin
         grant_next = RD;
      end else if (sel_strb == 4'hF || sel_strb == 4'h0) begin
         grant_next = WR;
      end else begin
         grant_next = RMW_RD;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         last_d  <= 1'b1;
         gnt_d   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_c || pick_d) begin
                  gnt_d   <= pick_d;
                  last_d  <= pick_d;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  wstrb_q <= sel_strb;
                  state   <= grant_next;
               end
            end
            RD:      state <= RD_WAIT;
            RMW_RD:  state <= RMW_WR;
            default: state <= IDLE;
         endcase
      end
   end

   // RAM strobes and completion are decoded from state so RMW can merge the
   // RAM word in the cycle it arrives; all strobes are killed during reset.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      done      = 1'b0;
      case (state)
         WR: begin
            ram_en    = 1'b1;
            ram_we    = (wstrb_q != 4'h0);
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
            done      = 1'b1;
         end
         RD, RMW_RD: begin
            ram_en   = 1'b1;
            ram_addr = addr_q;
         end
         RD_WAIT: done = 1'b1;
         RMW_WR: begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = addr_q;
            for (int i = 0; i < 4; i++) begin
               ram_wdata[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
            end
            done = 1'b1;
         end
         default: ;
      endcase
      if (!rst_n) begin
         ram_en = 1'b0;
         ram_we = 1'b0;
         done   = 1'b0;
      end
   end

   assign core_ready = done && !gnt_d;
   assign dbg_ready  = done && gnt_d;
   assign core_rdata = (core_ready && state == RD_WAIT) ? ram_rdata : 32'h0;
   assign dbg_rdata  = (dbg_ready && state == RD_WAIT) ? ram_rdata : 32'h0;
   assign core_hold  = core_req && !core_ready;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, cycle-level corner
// sequences and a randomized run against a transaction-level memory model.
module tb_mem_access_ctrl;
   localparam int unsigned AW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          core_req, core_we;
   logic [31:0]   core_addr, core_wdata;
   logic [3:0]    core_wstrb;
   logic [31:0]   core_rdata;
   logic          core_ready, core_hold;
   logic          dbg_req, dbg_we;
   logic [31:0]   dbg_addr, dbg_wdata, dbg_rdata;
   logic          dbg_ready;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata, ram_rdata;

   always #5 clk = ~clk;

   mem_access_ctrl #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_rdata(core_rdata),
      .core_ready(core_ready), .core_hold(core_hold),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Synchronous-read RAM with a back door for preloading.
   logic [31:0]   mem [0:4095];
   logic [31:0]   ref_mem [0:4095];
   logic [31:0]   rd_q;
   logic          pre_we;
   logic [AW-1:0] pre_idx;
   logic [31:0]   pre_val;
   int            wr_count = 0;

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_idx] <= pre_val;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         rd_q <= mem[ram_addr];
      end
   end
   always @(posedge clk) if (ram_en && ram_we) wr_count <= wr_count + 1;
   assign ram_rdata = rd_q;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] i, input logic [31:0] v);
      @(negedge clk);
      pre_idx = i; pre_val = v; pre_we = 1'b1;
      @(negedge clk);
      pre_we = 1'b0;
      ref_mem[i] = v;
   endtask

   // One transaction; reports latency (cycles after grant cycle) and RAM traffic.
   task automatic do_txn(input bit d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         output logic [31:0] rd, output int lat, output int rd_cyc,
                         output int wr_cyc, output logic [31:0] wr_val,
                         output logic [AW-1:0] en_addr);
      @(negedge clk);
      if (d) begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end else begin
         core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_wstrb = strb;
      end
      lat = -1; rd_cyc = 0; wr_cyc = 0; rd = '0; wr_val = '0; en_addr = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); #1;
         if (ram_en && rd_cyc == 0 && wr_cyc == 0) en_addr = ram_addr;
         if (ram_en && !ram_we && rd_cyc == 0) rd_cyc = c;
         if (ram_en && ram_we) begin wr_cyc = c; wr_val = ram_wdata; end
         if (d ? dbg_ready : core_ready) begin
            lat = c;
            rd  = d ? dbg_rdata : core_rdata;
            break;
         end
      end
      core_req = 1'b0;
      dbg_req  = 1'b0;
   endtask

   typedef struct {
      bit            d;
      bit            we;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic [3:0]    strb;
      logic [AW-1:0] idx;
      logic [31:0]   init;
      logic [31:0]   exp_word;
      int            lat;
      int            rd_cyc;
      int            wr_cyc;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [31:0]   rd, wv, tmp, addr, wdata, old_w, new_w;
      logic [AW-1:0] ea, ridx;
      logic [3:0]    strb;
      logic [2:0]    w3;
      logic [2:0]    got3, exp3;
      int            lat, rc, wc, w0, exp_lat, k, waited;
      bit            d, we, done_e, exp_c, exp_d;

      vecs[0] = '{d:0, we:1, addr:32'h20,      wdata:32'h000000AB, strb:4'b0001, idx:12'h008,
                  init:32'h11223344, exp_word:32'h112233AB, lat:2, rd_cyc:1, wr_cyc:2};
      vecs[1] = '{d:0, we:1, addr:32'h20,      wdata:32'h55660000, strb:4'b1100, idx:12'h008,
                  init:32'h11223344, exp_word:32'h55663344, lat:2, rd_cyc:1, wr_cyc:2};
      vecs[2] = '{d:1, we:1, addr:32'h8,       wdata:32'hCAFEF00D, strb:4'b0000, idx:12'h002,
                  init:32'h00000000, exp_word:32'hCAFEF00D, lat:1, rd_cyc:0, wr_cyc:1};
      vecs[3] = '{d:0, we:1, addr:32'h7FFC,    wdata:32'h12345678, strb:4'b1111, idx:12'hFFF,
                  init:32'h00000000, exp_word:32'h12345678, lat:1, rd_cyc:0, wr_cyc:1};
      vecs[4] = '{d:0, we:1, addr:32'h4010,    wdata:32'hFFFFFFFF, strb:4'b0000, idx:12'h004,
                  init:32'hA5A5A5A5, exp_word:32'hA5A5A5A5, lat:1, rd_cyc:1, wr_cyc:0};
      vecs[5] = '{d:1, we:0, addr:32'h31,      wdata:32'h0,        strb:4'b0000, idx:12'h00C,
                  init:32'h0BADF00D, exp_word:32'h0BADF00D, lat:2, rd_cyc:1, wr_cyc:0};
      vecs[6] = '{d:0, we:1, addr:32'h44,      wdata:32'hAA00BB00, strb:4'b1010, idx:12'h011,
                  init:32'h11223344, exp_word:32'hAA22BB44, lat:2, rd_cyc:1, wr_cyc:2};
      vecs[7] = '{d:0, we:0, addr:32'hFFFFF00C, wdata:32'h0,       strb:4'b0000, idx:12'hC03,
                  init:32'h600DCAFE, exp_word:32'h600DCAFE, lat:2, rd_cyc:1, wr_cyc:0};

      rst_n = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_wdata", ram_wdata, 32'd0);
      check("rst_readys", 32'({core_ready, dbg_ready}), 32'd0);
      check("rst_rdata", core_rdata | dbg_rdata, 32'd0);
      rst_n = 1'b1;

      // Core read of 0x10, cycle by cycle
      preload(12'd4, 32'hDEADBEEF);
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
      #1;
      check("rd_T_hold", 32'(core_hold), 32'd1);
      check("rd_T_en", 32'(ram_en), 32'd0);
      @(negedge clk); #1;
      check("rd_T1_en_we", 32'({ram_en, ram_we}), 32'b10);
      check("rd_T1_addr", 32'(ram_addr), 32'd4);
      check("rd_T1_hold_ready", 32'({core_hold, core_ready}), 32'b10);
      @(negedge clk); #1;
      check("rd_T2_ready", 32'(core_ready), 32'd1);
      check("rd_T2_rdata", core_rdata, 32'hDEADBEEF);
      check("rd_T2_hold", 32'(core_hold), 32'd0);
      core_req = 1'b0;
      @(negedge clk); #1;
      check("rd_T3_idle", 32'({core_ready, ram_en}), 32'd0);

      // Vector table
      foreach (vecs[i]) begin
         preload(vecs[i].idx, vecs[i].init);
         do_txn(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                rd, lat, rc, wc, wv, ea);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_rd_cyc", i), 32'(rc), 32'(vecs[i].rd_cyc));
         check($sformatf("vec%0d_wr_cyc", i), 32'(wc), 32'(vecs[i].wr_cyc));
         check($sformatf("vec%0d_ram_addr", i), 32'(ea), 32'(vecs[i].idx));
         if (vecs[i].wr_cyc != 0) check($sformatf("vec%0d_wdata", i), wv, vecs[i].exp_word);
         if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_word);
         @(negedge clk);
         check($sformatf("vec%0d_mem", i), mem[vecs[i].idx], vecs[i].exp_word);
         ref_mem[vecs[i].idx] = vecs[i].exp_word;
      end

      // Continuous tie from reset: completions every 3 cycles, alternating C, D
      preload(12'h040, 32'hC0C0C0C0);
      preload(12'h080, 32'hD0D0D0D0);
      @(negedge clk);
      rst_n = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
      dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h200;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc > 0) begin @(negedge clk); #1; end
         done_e = (cyc >= 2) && ((cyc - 2) % 3 == 0);
         k      = (cyc - 2) / 3;
         exp_c  = done_e && (k % 2 == 0);
         exp_d  = done_e && (k % 2 == 1);
         got3   = {core_ready, dbg_ready, core_hold};
         exp3   = {exp_c, exp_d, !exp_c};
         check($sformatf("tie_cyc%0d_rdy_hold", cyc), 32'(got3), 32'(exp3));
         if (exp_c) check($sformatf("tie_cyc%0d_crdata", cyc), core_rdata, 32'hC0C0C0C0);
         if (exp_d) check($sformatf("tie_cyc%0d_drdata", cyc), dbg_rdata, 32'hD0D0D0D0);
      end
      core_req = 1'b0; dbg_req = 1'b0;
      @(negedge clk);

      // Reset during RMW_RD, then C wins the first tie
      preload(12'd20, 32'h11111111);
      preload(12'd24, 32'h22222222);
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h50; core_wdata = 32'hFF; core_wstrb = 4'b0001;
      @(negedge clk); #1;
      check("rst_rmw_rd_phase", 32'({ram_en, ram_we}), 32'b10);
      w0 = wr_count;
      rst_n = 1'b0; core_req = 1'b0;
      @(negedge clk); #1;
      check("rst_rmw_no_ready_we", 32'({core_ready, dbg_ready, ram_we, ram_en}), 32'd0);
      rst_n = 1'b1;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h50;
      dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h60;
      @(negedge clk); #1;
      check("post_rst_grant_addr", 32'(ram_addr), 32'd20);
      @(negedge clk); #1;
      check("post_rst_c_ready", 32'({core_ready, dbg_ready}), 32'b10);
      check("post_rst_c_rdata", core_rdata, 32'h11111111);
      core_req = 1'b0;
      waited = -1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk); #1;
         if (dbg_ready) begin
            waited = c;
            check("post_rst_d_rdata", dbg_rdata, 32'h22222222);
            break;
         end
      end
      dbg_req = 1'b0;
      check("post_rst_d_wait", 32'(waited), 32'd3);
      check("rst_no_ram_write", 32'(wr_count - w0), 32'd0);

      // Randomized serial traffic over 8 aliased words
      for (int w = 0; w < 8; w++) preload(AW'(w), $urandom);
      for (int n = 0; n < 200; n++) begin
         d     = 1'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         tmp   = $urandom;
         w3    = 3'($urandom_range(0, 7));
         addr  = {tmp[31:14], 9'd0, w3, tmp[1:0]};
         wdata = $urandom;
         strb  = d ? 4'hF : 4'($urandom_range(0, 15));
         ridx  = AW'((addr >> 2) % (32'd1 << AW));
         old_w = ref_mem[ridx];
         if (we) begin
            new_w = old_w;
            for (int l = 0; l < 4; l++) if (strb[l]) new_w[8*l +: 8] = wdata[8*l +: 8];
            ref_mem[ridx] = new_w;
            exp_lat = (strb == 4'h0 || strb == 4'hF) ? 1 : 2;
         end else begin
            exp_lat = 2;
         end
         do_txn(d, we, addr, wdata, strb, rd, lat, rc, wc, wv, ea);
         check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
         if (!we) check($sformatf("rnd%0d_rdata", n), rd, old_w);
      end
      @(negedge clk);
      for (int w = 0; w < 8; w++) check($sformatf("rnd_mem%0d", w), mem[w], ref_mem[w]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences and arbitrates a single-port, synchronous-read data RAM between two requesters: the core load/store path (requester C) and a debug/program-loader port (requester D).
- Performs read-modify-write internally for sub-word stores, so the execution stage hands over a byte-strobed write and never merges read data itself.
- Stalls the pipeline through core_hold while a core access is outstanding.

Parameters:
- AW, 12: RAM word-address width; RAM depth is 2^AW 32-bit words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- core_req  in  1  core access request; held stable until core_ready
- core_we  in  1  1 = store, 0 = load
- core_addr  in  32  byte address
- core_wdata  in  32  store data, already lane-aligned
- core_wstrb  in  4  byte-lane enables for stores
- core_rdata  out  32  load data; valid only while core_ready = 1
- core_ready  out  1  one-cycle completion pulse
- core_hold  out  1  pipeline stall request
- dbg_req  in  1  debug access request; word-only; held until dbg_ready
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  32  byte address
- dbg_wdata  in  32  write data
- dbg_rdata  out  32  read data; valid only while dbg_ready = 1
- dbg_ready  out  1  one-cycle completion pulse
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data; valid the cycle after ram_en with ram_we = 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state = IDLE; ram_en, ram_we, core_ready, dbg_ready = 0; ram_addr, ram_wdata, core_rdata, dbg_rdata = 0; last_grant = D, so C wins the first tie.
- States: IDLE, WR, RD, RD_WAIT, RMW_RD, RMW_WR.
- IDLE, arbitration:
  - If exactly one req is high, that requester is granted.
  - If both are high, grant goes to the requester that is not last_grant (round-robin). last_grant updates on every grant.
  - On grant, latch we, addr, wdata and wstrb into internal registers. dbg wstrb is forced to 4'hF.
- Next state from IDLE on grant:
  - we = 0 -> RD.
  - we = 1 and wstrb = 4'hF -> WR.
  - we = 1 and wstrb = 0 -> WR with ram_we = 0. This is a no-op that still completes.
  - Any other strobe -> RMW_RD.
  - No request -> stay in IDLE.
- ram_addr = latched addr[AW+1:2]. Upper address bits are ignored, so accesses alias or wrap. addr[1:0] is ignored.
- Grant in cycle T, cycle-level sequence:
  - Full write: T+1 WR, ram_en = 1, ram_we = 1, ram_wdata = wdata, ready = 1; then IDLE.
  - Read: T+1 RD, ram_en = 1, ram_we = 0. T+2 RD_WAIT, ready = 1, rdata = ram_rdata. Then IDLE.
  - Partial write: T+1 RMW_RD, ram_en = 1, ram_we = 0. T+2 RMW_WR, ram_en = 1, ram_we = 1. For each byte lane i, ram_wdata lane i = wstrb[i] ? wdata lane i : ram_rdata lane i. ready = 1 in T+2. Then IDLE.
- ram_en, ram_we, ram_addr and ram_wdata are decoded from state and latched registers. They are 0 in IDLE.
- Completion signalling:
  - core_ready and dbg_ready are single-cycle pulses, asserted only for the granted requester.
  - The requester must drop or change req in the cycle after ready. IDLE re-samples then, so every transaction has at least one IDLE cycle between transactions.
- core_hold = core_req AND NOT core_ready, combinational. It is therefore high in cycle T while C waits in IDLE, including while it loses arbitration.
- A req that deasserts mid-transaction does not abort; the transaction completes and ready still pulses.
- When the non-granted requester is waiting, it is granted at the next IDLE cycle, so worst-case wait is one transaction.
- Reset asserted mid-transaction: next state is IDLE. No ready pulse is issued and no RAM write occurs in the reset cycle.

Test Plan:
- Reset, then C reads addr 0x10 with RAM word 4 = 0xDEADBEEF. Required: ram_en in T+1 with ram_addr = 4; core_ready and core_rdata = 0xDEADBEEF in T+2; core_hold high in T and T+1, low in T+2.
- C stores 0x000000AB, wstrb 4'b0001, to addr 0x20 holding 0x11223344. Required: read in T+1, write 0x112233AB in T+2, core_ready in T+2. Repeat with wstrb 4'b1100, data 0x55660000: RAM word becomes 0x55663344.
- dbg full write of 0xCAFEF00D to 0x8. Required: single-cycle write in T+1, dbg_ready in T+1, no read cycle issued.
- C and D requesting simultaneously and continuously from reset. Required: grant order C, D, C, D. Each transaction is separated by one IDLE cycle. core_hold stays high while D is served.
- core_we = 1 with wstrb = 0. Required: core_ready in T+1, ram_we = 0, RAM contents unchanged. Address 0x4010 with AW = 12: ram_addr = 0x004 (wrap).
- rst_n low during RMW_RD. Required: next cycle IDLE, no write strobe, no ready pulse. After reset, C wins a tie against D.
